micro_cmd_master: RTL and testbench

Hardware initiator for the micro-to-register-file GPIO command protocol. Takes high-level command requests (kernel select, frame load/end, frame-ready poll, frame get), serializes each one onto the 32-bit command word as a setup/strobe/release enable sequence, and returns the register file's read-back word for query commands. It sits where the MicroBlaze gpi0/gpo0 pair would connect, replacing software bit-banging in soft-processor-less builds and in system-level benches.

---
 rtl/micro_cmd_master.sv | 130 +++++++++++++
 tb/tb_micro_cmd_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_cmd_master.sv
// rtl/micro_cmd_master.sv - serializes command requests into setup/strobe/release words on the register-file GPIO bus
// Optional: define MICRO_CMD_CHECK_EN to reject command codes above GET_FRAME with an o_err pulse.
module micro_cmd_master #(
  parameter int NB_COM      = 7,
  parameter int NB_DATA     = 24,
  parameter int NB_INST     = 32,
  parameter int HOLD_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [NB_COM-1:0]  i_req_cmd,
  input  logic [NB_DATA-1:0] i_req_data,
  output logic [NB_INST-1:0] o_cmd_to_regs,
  input  logic [NB_INST-1:0] i_data_from_regs,
  output logic               o_rsp_valid,
  output logic [NB_INST-1:0] o_rsp_data,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_CAPTURE
  } state_t;

  localparam logic [7:0]        HOLD_LAST          = 8'(HOLD_CYCLES - 1);
  localparam logic [NB_COM-1:0] CMD_IS_FRAME_READY = NB_COM'(3);
  localparam logic [NB_COM-1:0] CMD_GET_FRAME      = NB_COM'(4);

  state_t              state;
  logic [7:0]          phase_cnt;
  logic [NB_COM-1:0]   cmd_q;
  logic [NB_DATA-1:0]  data_q;
  logic                is_read;
  logic                req_bad;

  assign is_read = (cmd_q == CMD_IS_FRAME_READY) || (cmd_q == CMD_GET_FRAME);

`ifdef MICRO_CMD_CHECK_EN
  assign req_bad = (i_req_cmd > CMD_GET_FRAME);
`else
  assign req_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      phase_cnt     <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      o_cmd_to_regs <= '0;
      o_rsp_data    <= '0;
      o_rsp_valid   <= 1'b0;
      o_err         <= 1'b0;
      o_busy        <= 1'b0;
      o_req_ready   <= 1'b1;
    end else begin
      o_rsp_valid <= 1'b0;
      o_err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            if (req_bad) begin
              // Rejected codes are consumed without touching the bus word.
              o_err <= 1'b1;
            end else begin
              cmd_q         <= i_req_cmd;
              data_q        <= i_req_data;
              phase_cnt     <= HOLD_LAST;
              o_cmd_to_regs <= {1'b0, i_req_cmd, i_req_data};
              o_busy        <= 1'b1;
              o_req_ready   <= 1'b0;
              state         <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (phase_cnt == 8'd0) begin
            phase_cnt     <= HOLD_LAST;
            o_cmd_to_regs <= {1'b1, cmd_q, data_q};
            state         <= ST_STROBE;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (phase_cnt == 8'd0) begin
            phase_cnt     <= HOLD_LAST;
            o_cmd_to_regs <= {1'b0, cmd_q, data_q};
            state         <= ST_RELEASE;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        ST_RELEASE: begin
          if (phase_cnt == 8'd0) begin
            if (is_read) begin
              // Read-back is sampled on the edge that ends RELEASE.
              o_rsp_data  <= i_data_from_regs;
              o_rsp_valid <= 1'b1;
              state       <= ST_CAPTURE;
            end else begin
              o_busy      <= 1'b0;
              o_req_ready <= 1'b1;
              state       <= ST_IDLE;
            end
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end
        ST_CAPTURE: begin
          o_busy      <= 1'b0;
          o_req_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          o_busy      <= 1'b0;
          o_req_ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_cmd_master.sv
// tb/tb_micro_cmd_master.sv - self-checking bench for micro_cmd_master (H=1 and H=3 instances)
module tb_micro_cmd_master;

  typedef struct {
    logic [6:0]  cmd;
    logic [23:0] data;
    logic [31:0] rdback;
    logic [31:0] exp_setup;
    logic [31:0] exp_strobe;
    bit          is_read;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        valid1, ready1, rsp_valid1, busy1, err1;
  logic [6:0]  cmd1;
  logic [23:0] data1;
  logic [31:0] regs1, ocmd1, rsp_data1;

  logic        valid3, ready3, rsp_valid3, busy3, err3;
  logic [6:0]  cmd3;
  logic [23:0] data3;
  logic [31:0] regs3, ocmd3, rsp_data3;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          exp_pulses = 0;
  logic        prev_en = 1'b0;
  logic [31:0] sb[$];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  micro_cmd_master #(.HOLD_CYCLES(1)) dut1 (
    .clock(clk), .reset(reset),
    .i_req_valid(valid1), .o_req_ready(ready1),
    .i_req_cmd(cmd1), .i_req_data(data1),
    .o_cmd_to_regs(ocmd1), .i_data_from_regs(regs1),
    .o_rsp_valid(rsp_valid1), .o_rsp_data(rsp_data1),
    .o_busy(busy1), .o_err(err1)
  );

  micro_cmd_master #(.HOLD_CYCLES(3)) dut3 (
    .clock(clk), .reset(reset),
    .i_req_valid(valid3), .o_req_ready(ready3),
    .i_req_cmd(cmd3), .i_req_data(data3),
    .o_cmd_to_regs(ocmd3), .i_data_from_regs(regs3),
    .o_rsp_valid(rsp_valid3), .o_rsp_data(rsp_data3),
    .o_busy(busy3), .o_err(err3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: responses pushed at request time, popped when o_rsp_valid fires.
  always @(negedge clk) begin
    if (ocmd1[31] && !prev_en) pulses++;
    prev_en = ocmd1[31];
    if (rsp_valid1 === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%h expected=none", rsp_data1);
      end else begin
        chk("rsp_data", rsp_data1, sb.pop_front());
      end
    end
  end

  task automatic send1(input vec_t v);
    int n = 0;
    while (ready1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready1 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=%b expected=1", ready1);
    end
    valid1 = 1'b1;
    cmd1   = v.cmd;
    data1  = v.data;
    regs1  = v.rdback;
    if (v.is_read) sb.push_back(v.rdback);
    exp_pulses++;
    @(negedge clk);
    valid1 = 1'b0;
    chk("setup_word", ocmd1, v.exp_setup);
    chk("setup_busy", {31'd0, busy1}, 32'd1);
    chk("setup_err", {31'd0, err1}, 32'd0);
    @(negedge clk);
    chk("strobe_word", ocmd1, v.exp_strobe);
    @(negedge clk);
    chk("release_word", ocmd1, v.exp_setup);
    @(negedge clk);
    if (v.is_read) begin
      chk("capture_busy", {31'd0, busy1}, 32'd1);
    end else begin
      chk("idle_ready", {31'd0, ready1}, 32'd1);
      chk("idle_word", ocmd1, v.exp_setup);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{7'd0, 24'h000003, 32'h0,        32'h00000003, 32'h80000003, 1'b0};
    vecs[1] = '{7'd3, 24'h000000, 32'h00000001, 32'h03000000, 32'h83000000, 1'b1};
    vecs[2] = '{7'd1, 24'h2BFF1D, 32'h0,        32'h012BFF1D, 32'h812BFF1D, 1'b0};
    vecs[3] = '{7'd2, 24'h00FF00, 32'h0,        32'h0200FF00, 32'h8200FF00, 1'b0};
    vecs[4] = '{7'd4, 24'h000010, 32'hDEADBEEF, 32'h04000010, 32'h84000010, 1'b1};
    vecs[5] = '{7'd0, 24'hFFFFFF, 32'h0,        32'h00FFFFFF, 32'h80FFFFFF, 1'b0};

    reset  = 1'b1;
    valid1 = 1'b0; cmd1 = '0; data1 = '0; regs1 = '0;
    valid3 = 1'b0; cmd3 = '0; data3 = '0; regs3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", ocmd1, 32'h0);
    chk("rst_rsp_data", rsp_data1, 32'h0);
    chk("rst_rsp_valid", {31'd0, rsp_valid1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_ready", {31'd0, ready1}, 32'd1);
    chk("rst_ready3", {31'd0, ready3}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) send1(vecs[i]);
    while (ready1 !== 1'b1) @(negedge clk);

    // Reset during STROBE of a read: enable drops, no response.
    valid1 = 1'b1; cmd1 = 7'd4; data1 = 24'h123456; regs1 = 32'h55;
    exp_pulses++;
    @(negedge clk);
    valid1 = 1'b0;
    @(negedge clk);
    chk("pre_rst_strobe", ocmd1, 32'h84123456);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_cmd", ocmd1, 32'h0);
    chk("midrst_busy", {31'd0, busy1}, 32'd0);
    chk("midrst_ready", {31'd0, ready1}, 32'd1);
    repeat (5) @(negedge clk);

    // Reset together with a request: request is dropped.
    reset = 1'b1; valid1 = 1'b1; cmd1 = 7'd0; data1 = 24'h777777;
    @(negedge clk);
    reset = 1'b0; valid1 = 1'b0;
    chk("rstreq_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    chk("rstreq_busy2", {31'd0, busy1}, 32'd0);
    chk("rstreq_cmd", ocmd1, 32'h0);

    send1(vecs[0]);

`ifdef MICRO_CMD_CHECK_EN
    begin
      logic [31:0] last;
      last = ocmd1;
      valid1 = 1'b1; cmd1 = 7'd5; data1 = 24'h000042;
      @(negedge clk);
      valid1 = 1'b0;
      chk("bad_err", {31'd0, err1}, 32'd1);
      chk("bad_cmd", ocmd1, last);
      chk("bad_busy", {31'd0, busy1}, 32'd0);
      @(negedge clk);
      chk("bad_err_clear", {31'd0, err1}, 32'd0);
      chk("bad_cmd2", ocmd1, last);
      chk("bad_ready", {31'd0, ready1}, 32'd1);
    end
`else
    begin
      vec_t v5;
      v5 = '{7'd5, 24'h000042, 32'h0, 32'h05000042, 32'h85000042, 1'b0};
      send1(v5);
    end
`endif
    repeat (3) @(negedge clk);

    // H=3 read: each phase lasts three cycles, response at t0+10.
    valid3 = 1'b1; cmd3 = 7'd4; data3 = 24'h000000; regs3 = 32'h00ABCDEF;
    @(negedge clk);
    valid3 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("h3_word_%0d", k), ocmd3, (k >= 4 && k <= 6) ? 32'h84000000 : 32'h04000000);
      chk($sformatf("h3_rspv_%0d", k), {31'd0, rsp_valid3}, (k == 10) ? 32'd1 : 32'd0);
      chk($sformatf("h3_busy_%0d", k), {31'd0, busy3}, (k <= 10) ? 32'd1 : 32'd0);
      if (k >= 10) chk($sformatf("h3_rspd_%0d", k), rsp_data3, 32'h00ABCDEF);
      @(negedge clk);
    end
    chk("h3_ready", {31'd0, ready3}, 32'd1);
    chk("h3_err", {31'd0, err3}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    chk("enable_pulses", pulses, exp_pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
